cpu_seq: RTL

//  Multi-cycle fetch/execute sequencer for the comproc CPU core.

---
 rtl/cpu_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle fetch/execute sequencer for the comproc CPU core.
//
// Shares one 16-bit memory port between instruction fetch (at ip) and the
// data access asked for by the instruction decoder. exec_en is a one-cycle
// strobe that gates every datapath register update (stk, fp, ip, call stack).
//
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   ip                  instruction byte address (bit0 ignored on fetch)
//   daddr, dwdata       data address and store data
//   rd_mem, wr_mem, byt decoder outputs, combinational from insn
//   halt_req            level request to halt at the next instruction boundary
//   mem_rdata, mem_ready  memory response
//   mem_addr, mem_wdata, mem_be, mem_rd, mem_wr  memory request
//   insn, rdata         latched instruction / latched load data
//   exec_en             datapath commit strobe
//   halted              high while in HALT
//   bus_err             sticky error flag, cleared only by rst
module cpu_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ip,
  input  logic [15:0] daddr,
  input  logic [15:0] dwdata,
  input  logic        rd_mem,
  input  logic        wr_mem,
  input  logic        byt,
  input  logic        halt_req,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] insn,
  output logic [15:0] rdata,
  output logic        exec_en,
  output logic        halted,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    DATA   = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wcnt;
  logic          req_active;
  logic          timeout;
  logic          conflict;

  // Byte loads return the addressed lane zero-extended; word loads pass through.
  function automatic logic [15:0] load_extract(input logic [15:0] d,
                                               input logic        b,
                                               input logic        a0);
    if (!b)
      return d;
    return {8'h00, a0 ? d[15:8] : d[7:0]};
  endfunction

  // A byte store replicates the low byte so either lane carries it.
  function automatic logic [15:0] store_data(input logic [15:0] d,
                                             input logic        b);
    return b ? {d[7:0], d[7:0]} : d;
  endfunction

  assign req_active = (state == FETCH) || (state == DATA);
  // Timeout fires on the TIMEOUT-th consecutive cycle without mem_ready.
  assign timeout    = req_active && !mem_ready && (wcnt == CW'(TIMEOUT - 1));
  assign conflict   = (state == DECODE) && rd_mem && wr_mem;

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= FETCH;
    else
      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (timeout)
          next_state = HALT;
        else if (mem_ready)
          next_state = DECODE;
      end
      DECODE: begin
        if (conflict)
          next_state = HALT;
        else if (rd_mem || wr_mem)
          next_state = DATA;
        else
          next_state = EXEC;
      end
      DATA: begin
        if (timeout)
          next_state = HALT;
        else if (mem_ready)
          next_state = EXEC;
      end
      EXEC: begin
        next_state = halt_req ? HALT : FETCH;
      end
      HALT: begin
        if (!halt_req && !bus_err)
          next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  // Outputs; rst forces the request low in the same cycle it is raised.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_be    = 2'b00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    exec_en   = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_addr = {ip[15:1], 1'b0};
          mem_be   = 2'b11;
          mem_rd   = 1'b1;
        end
        DATA: begin
          mem_addr  = byt ? daddr : {daddr[15:1], 1'b0};
          mem_be    = byt ? (daddr[0] ? 2'b10 : 2'b01) : 2'b11;
          mem_wdata = store_data(dwdata, byt);
          mem_rd    = rd_mem;
          // Read wins so the two strobes can never overlap.
          mem_wr    = wr_mem && !rd_mem;
        end
        EXEC:    exec_en = 1'b1;
        HALT:    halted  = 1'b1;
        default: ;
      endcase
    end
  end

  // Wait counter, error flag and latched instruction / load data
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt    <= '0;
      bus_err <= 1'b0;
      insn    <= 16'h0000;
      rdata   <= 16'h0000;
    end else begin
      if (!req_active || mem_ready)
        wcnt <= '0;
      else
        wcnt <= wcnt + 1'b1;

      if (timeout || conflict)
        bus_err <= 1'b1;

      if (state == FETCH && mem_ready)
        insn <= mem_rdata;

      if (state == DATA && mem_ready && rd_mem)
        rdata <= load_extract(mem_rdata, byt, daddr[0]);
    end
  end

endmodule
